// File: rtl/alu_seq.sv
// alu_seq: handshaked eight-opcode ALU; MUL is a WIDTH-cycle shift-add multiplier.
// Optional {N,V,C,Z} flags output is built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
`ifdef ALU_SEQ_FLAGS_EN
  output logic [3:0]       flags,
`endif
  output logic [1:0]       dbg_state
);
  // Handshake: a transfer occurs on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and out_valid/res stay stable until taken.

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      sh;
  logic [SW-1:0]      cnt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic               accept, is_mul, mul_last;

  assign sh        = b[SW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_ctrl == 3'b111);
  assign mul_last  = (cnt == SW'(WIDTH - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_mul ? BUSY : DONE;
      BUSY:    if (mul_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      3'b000:  alu_res = a + b;
      3'b001:  alu_res = a - b;
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = a << sh;
      3'b110:  alu_res = a >> sh;
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per BUSY cycle: add the shifted multiplicand when the bit is set.
  assign acc_nx = mplier[0] ? (acc + mcand) : acc;

`ifdef ALU_SEQ_FLAGS_EN
  logic       alu_c, alu_v;
  logic [3:0] alu_flags, mul_flags;

  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_c = (alu_res < a);
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_c = (a < b);
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      // Last bit shifted out; a zero shift shifts nothing out.
      3'b101:  alu_c = (sh != '0) && (((a >> (WIDTH - int'(sh))) & WIDTH'(1)) != '0);
      3'b110:  alu_c = (sh != '0) && (((a >> (int'(sh) - 1)) & WIDTH'(1)) != '0);
      default: ;
    endcase
    alu_flags = {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
    mul_flags = {acc_nx[WIDTH-1], 1'b0, (acc_nx[2*WIDTH-1:WIDTH] != '0), (acc_nx == '0)};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res    <= '0;
      res_hi <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flags  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              res    <= alu_res;
              res_hi <= '0;
`ifdef ALU_SEQ_FLAGS_EN
              flags  <= alu_flags;
`endif
            end
          end
        end
        BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SW'(1);
          if (mul_last) begin
            res    <= acc_nx[WIDTH-1:0];
            res_hi <= acc_nx[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_FLAGS_EN
            flags  <= mul_flags;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept a new operation.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 alu_ctrl  input  3  opcode.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 res  output  WIDTH  result (low half for MUL).
REQ-012 res_hi  output  WIDTH  MUL high half; 0 for all other opcodes.
REQ-013 flags  output  4  {N,V,C,Z}; present only per REQ-032.

Function
REQ-014 Opcodes: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL (a<<b[log2(WIDTH)-1:0]), 110 SHR logical, 111 MUL unsigned.
REQ-015 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-016 Accept on rising edge with in_valid&&in_ready; a, b, alu_ctrl captured into internal registers at that edge; later input changes ignored until next accept.
REQ-017 Opcodes 000-110: IDLE->DONE on accept; res valid with out_valid=1 one cycle after accept (latency 1).
REQ-018 MUL: IDLE->BUSY on accept; shift-add one multiplier bit per cycle for WIDTH cycles; BUSY->DONE after WIDTH-th iteration; out_valid asserts WIDTH+1 cycles after accept.
REQ-019 MUL product is 2*WIDTH bits: {res_hi,res} = a*b, no truncation.
REQ-020 ADD/SUB results wrap modulo 2^WIDTH.
REQ-021 Shift amount uses only low log2(WIDTH) bits of b; upper b bits ignored.
REQ-022 DONE: res, res_hi, flags, out_valid held stable while out_ready=0.
REQ-023 DONE with out_ready=1: DONE->IDLE, out_valid=0 next cycle; res/res_hi keep last value.
REQ-024 No back-to-back overlap: new accept earliest the cycle after out_valid handshake (in_ready=1 in IDLE).
REQ-025 in_valid in BUSY/DONE is ignored, not queued.
REQ-026 out_ready while not out_valid has no effect.

Reset
REQ-027 rst_n=0 at rising edge: state IDLE, out_valid=0, res=0, res_hi=0, flags=0, internal operand/accumulator registers=0, iteration counter=0.
REQ-028 in_ready=1 the cycle after reset release.
REQ-029 Reset during BUSY or DONE aborts the operation; no out_valid pulse for the aborted operation.

Configuration
REQ-030 Macro ALU_SEQ_FLAGS_EN.
REQ-031 Without it: no flags port, no flag logic.
REQ-032 With it: flags port exists, updated with res. Z=(res==0, and res_hi==0 for MUL); N=res[WIDTH-1]; C=ADD carry-out, SUB borrow (a<b unsigned), SHL last bit shifted out, SHR last bit shifted out, MUL (res_hi!=0), else 0; V=signed overflow for ADD/SUB, else 0.
REQ-033 Flags held/reset identically to res.

Verification (WIDTH=8)
REQ-034 ADD a=0xF0 b=0x20 -> out_valid 1 cycle after accept, res=0x10, flags C=1 Z=0 V=0 N=0.
REQ-035 SUB a=0x7F b=0xFF -> res=0x80, V=1, C=1, N=1; SUB a=0x05 b=0x05 -> res=0x00, Z=1.
REQ-036 MUL a=0xFF b=0xFF -> in_ready=0 for 9 cycles, out_valid 9 cycles after accept, {res_hi,res}=0xFE01; MUL a=0x00 b=0x37 -> 0x0000, Z=1.
REQ-037 SHL a=0x81 b=0x09 -> shift 1, res=0x02, C=1; SHR a=0x81 b=0x07 -> res=0x01.
REQ-038 Backpressure: ADD result with out_ready=0 for 5 cycles -> res and out_valid stable, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-039 rst_n=0 on 4th BUSY cycle of MUL -> next cycle out_valid=0, res=0, in_ready=1 after release; no stale result appears.
